lecture8_1_reg4: RTL and testbench

//   Parallel-load register with synchronous reset and load enable (4 bits by default).

---
 rtl/lecture8_1_reg4.sv | 37 +++
 tb/tb_lecture8_1_reg4.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/lecture8_1_reg4.sv
// Parallel-load register with synchronous active-high reset and load enable.
// Q is driven straight from the storage flops, so there is no combinational
// path from D, load or reset to Q. Until the first edge that sees reset or
// load, Q holds whatever the flops powered up with (X in simulation).
module lecture8_1_reg4 #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value when not in reset: take D on load, otherwise keep the current value.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = D;
    end
  end

  // Storage flops; reset is sampled only on the edge and takes priority over load.
  always_ff @(posedge Clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_lecture8_1_reg4.sv
// Bench for lecture8_1_reg4: table-driven directed vectors, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
`timescale 1ns/100ps
module tb_lecture8_1_reg4;

  localparam int W = 4;

  // Clock and DUT signals
  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[64];

  // Scoreboard queue for the randomized phase
  logic [W-1:0] exp_q[$];

  lecture8_1_reg4 #(.WIDTH(W)) dut (
    .Clk   (clk),
    .reset (reset),
    .load  (load),
    .D     (d),
    .Q     (q)
  );

  // Clock: 2 ns period
  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Advance one rising edge; return 0.5 ns later, safely between edges.
  task automatic step();
    @(posedge clk);
    #0.5;
  endtask

  task automatic drive(input logic r, input logic l, input logic [W-1:0] v);
    reset = r;
    load  = l;
    d     = v;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: Q=%h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [W-1:0] model_q;
    logic [W-1:0] held;
    logic         r;
    logic         l;
    logic [W-1:0] v;

    // Directed vector table: 4 scenarios x 16 D values.
    for (int i = 0; i < 16; i++) begin
      // 1: reset beats load
      vecs[i]      = '{rst: 1'b1, ld: 1'b1, din: W'(i), exp: '0};
      // 2: hold after reset, D ignored
      vecs[16 + i] = '{rst: 1'b0, ld: 1'b0, din: W'(i), exp: '0};
      // 3: reset with load low
      vecs[32 + i] = '{rst: 1'b1, ld: 1'b0, din: W'(i), exp: '0};
      // 4: continuous load, Q is the D sampled at the edge just taken
      vecs[48 + i] = '{rst: 1'b0, ld: 1'b1, din: W'(i), exp: W'(i)};
    end

    drive(1'b0, 1'b0, '0);
    #0.5;

    // Reset state after a single reset edge
    drive(1'b1, 1'b0, 4'h9);
    step();
    check("reset_state", q, '0);

    for (int i = 0; i < 64; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].din);
      step();
      check($sformatf("vec%0d", i), q, vecs[i].exp);
    end
    check("full_width_F", q, 4'hF);

    // 5: load A, hold it against D=5 for 3 edges, then reset for 1 edge
    drive(1'b0, 1'b1, 4'hA);
    step();
    check("load_A", q, 4'hA);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'h5);
      step();
      check($sformatf("hold_A_%0d", i), q, 4'hA);
    end
    drive(1'b1, 1'b0, 4'h5);
    step();
    check("reset_after_hold", q, '0);
    drive(1'b0, 1'b0, 4'h3);
    step();
    check("stay_zero_no_load", q, '0);

    // 6: reset pulse strictly between edges leaves Q alone
    drive(1'b0, 1'b1, 4'h7);
    step();
    check("load_7", q, 4'h7);
    drive(1'b0, 1'b0, 4'h7);
    reset = 1'b1;
    #0.4;
    reset = 1'b0;
    check("mid_cycle_reset_no_effect", q, 4'h7);
    step();
    check("after_mid_cycle_reset", q, 4'h7);

    // Glitch on D/load between edges has no effect
    load = 1'b1;
    d    = 4'hC;
    #0.3;
    load = 1'b0;
    d    = 4'h1;
    step();
    check("mid_cycle_load_glitch", q, 4'h7);

    // Randomized phase: model keeps the last value written to the register.
    model_q = q;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 1) == 1);
      v = W'($urandom);
      drive(r, l, v);
      if (r)      held = '0;
      else if (l) held = v;
      else        held = model_q;
      model_q = held;
      exp_q.push_back(held);
      step();
      check($sformatf("rand%0d", i), q, exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
